// File: rtl/uart_fifo_mmio_if.sv
// Processor data-bus slot for uart_fifo_mmio: 16-bit byte address, 32-bit data,
// single-cycle read/write strobes, combinational read data and a level interrupt.
interface uart_fifo_mmio_if;
    logic [15:0] address;
    logic [31:0] w_data;
    logic        we;
    logic        re;
    logic [31:0] r_data;
    logic        irq;

    modport master (output address, w_data, we, re, input r_data, irq);
    modport slave  (input address, w_data, we, re, output r_data, irq);
endinterface

// File: rtl/uart_fifo_mmio.sv
// Memory-mapped UART with RX/TX FIFOs, sticky W1C error flags and a registered level irq.
// Define UART_PARITY_EN to add one even-parity bit per frame in both directions.
module uart_fifo_mmio #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_Rx,
    output logic            o_Tx,
    uart_fifo_mmio_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [1:0] REG_DATA = 2'd0, REG_STATUS = 2'd1, REG_CTRL = 2'd2, REG_DIV = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

    logic [1:0] reg_sel;
    logic       status_wr;
    logic       unused_bus_bits;
    assign reg_sel         = bus.address[3:2];
    assign status_wr       = bus.we && (reg_sel == REG_STATUS);
    assign unused_bus_bits = ^{bus.address[15:4], bus.address[1:0], bus.w_data[31:16]};

    // Index 0 is the RX FIFO, index 1 the TX FIFO.
    logic [1:0]           fifo_push, fifo_pop, fifo_empty, fifo_full, fifo_accept;
    logic [DATA_BITS-1:0] fifo_wdata [2];
    logic [DATA_BITS-1:0] fifo_head  [2];
    logic [7:0]           fifo_count8 [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
            logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
            logic [PW-1:0]        count;
            logic                 push_ok, pop_ok;

            assign count            = wr_ptr_reg - rd_ptr_reg;
            assign fifo_empty[gi]   = (count == '0);
            assign fifo_full[gi]    = (count == PW'(FIFO_DEPTH));
            assign pop_ok           = fifo_pop[gi] && !fifo_empty[gi];
            // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
            assign push_ok          = fifo_push[gi] && (!fifo_full[gi] || pop_ok);
            assign fifo_accept[gi]  = push_ok;
            assign fifo_head[gi]    = fifo_empty[gi] ? '0 : mem[rd_ptr_reg[AW-1:0]];
            assign fifo_count8[gi]  = 8'(count);

            always_ff @(posedge clk) begin
                if (push_ok)
                    mem[wr_ptr_reg[AW-1:0]] <= fifo_wdata[gi];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
            end
        end
    endgenerate

    logic [2:0]  ctrl_reg;
    logic [15:0] div_reg;
    logic        frame_err_reg, overrun_err_reg, parity_err, irq_reg;
    logic        tx_pop, tx_busy;

    // ---------------- receiver ----------------
    uart_state_t          rx_state_reg;
    logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [15:0]          rx_cnt_reg, rx_div_reg;
    logic [2:0]           rx_bit_reg;
    logic [DATA_BITS-1:0] rx_shift_reg;
    logic                 rx_push_reg, frame_set_reg, parity_set_reg;
    logic                 rx_bit_end;

    assign rx_bit_end = (rx_cnt_reg == rx_div_reg - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            rx_prev_reg    <= 1'b1;
            rx_state_reg   <= S_IDLE;
            rx_cnt_reg     <= '0;
            rx_div_reg     <= 16'(CLKS_PER_BIT);
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_push_reg    <= 1'b0;
            frame_set_reg  <= 1'b0;
            parity_set_reg <= 1'b0;
        end else begin
            rx_meta_reg    <= i_Rx;
            rx_sync_reg    <= rx_meta_reg;
            rx_prev_reg    <= rx_sync_reg;
            rx_push_reg    <= 1'b0;
            frame_set_reg  <= 1'b0;
            parity_set_reg <= 1'b0;
            case (rx_state_reg)
                S_IDLE: begin
                    // Edge-triggered so a line still low after a bad stop bit does not retrigger.
                    if (rx_prev_reg && !rx_sync_reg) begin
                        rx_state_reg <= S_START;
                        rx_cnt_reg   <= '0;
                        rx_div_reg   <= div_reg;
                    end
                end
                S_START: begin
                    if (rx_cnt_reg == {1'b0, rx_div_reg[15:1]} - 16'd1) begin
                        rx_cnt_reg   <= '0;
                        rx_bit_reg   <= '0;
                        rx_state_reg <= rx_sync_reg ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                        rx_bit_reg   <= rx_bit_reg + 3'd1;
                        if (rx_bit_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            rx_state_reg <= S_PARITY;
`else
                            rx_state_reg <= S_STOP;
`endif
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (rx_bit_end) begin
                        rx_cnt_reg <= '0;
                        if (rx_sync_reg != ^rx_shift_reg) begin
                            parity_set_reg <= 1'b1;
                            rx_state_reg   <= S_IDLE;
                        end else begin
                            rx_state_reg <= S_STOP;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    if (rx_bit_end) begin
                        rx_cnt_reg    <= '0;
                        rx_push_reg   <= rx_sync_reg;
                        frame_set_reg <= !rx_sync_reg;
                        rx_state_reg  <= S_IDLE;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 16'd1;
                    end
                end
            endcase
        end
    end

    assign fifo_push[0]  = rx_push_reg;
    assign fifo_wdata[0] = rx_shift_reg;
    assign fifo_pop[0]   = bus.re && (reg_sel == REG_DATA);

    // ---------------- transmitter ----------------
    uart_state_t          tx_state_reg;
    logic                 tx_reg;
    logic [15:0]          tx_cnt_reg, tx_div_reg;
    logic [2:0]           tx_bit_reg;
    logic [DATA_BITS-1:0] tx_shift_reg;
    logic                 tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 tx_par_reg;
`endif

    assign tx_bit_end = (tx_cnt_reg == tx_div_reg - 16'd1);
    // Popping at the end of STOP chains frames with no idle gap.
    assign tx_pop     = !fifo_empty[1] &&
                        ((tx_state_reg == S_IDLE) || (tx_state_reg == S_STOP && tx_bit_end));
    assign tx_busy    = (tx_state_reg != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_reg <= S_IDLE;
            tx_reg       <= 1'b1;
            tx_cnt_reg   <= '0;
            tx_div_reg   <= 16'(CLKS_PER_BIT);
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
`ifdef UART_PARITY_EN
            tx_par_reg   <= 1'b0;
`endif
        end else if (tx_pop) begin
            tx_state_reg <= S_START;
            tx_reg       <= 1'b0;
            tx_cnt_reg   <= '0;
            tx_div_reg   <= div_reg;
            tx_shift_reg <= fifo_head[1];
`ifdef UART_PARITY_EN
            tx_par_reg   <= ^fifo_head[1];
`endif
        end else if (tx_state_reg != S_IDLE) begin
            if (tx_bit_end) begin
                tx_cnt_reg <= '0;
                case (tx_state_reg)
                    S_START: begin
                        tx_reg       <= tx_shift_reg[0];
                        tx_bit_reg   <= '0;
                        tx_state_reg <= S_DATA;
                    end
                    S_DATA: begin
                        if (tx_bit_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            tx_reg       <= tx_par_reg;
                            tx_state_reg <= S_PARITY;
`else
                            tx_reg       <= 1'b1;
                            tx_state_reg <= S_STOP;
`endif
                        end else begin
                            tx_shift_reg <= tx_shift_reg >> 1;
                            tx_reg       <= tx_shift_reg[1];
                            tx_bit_reg   <= tx_bit_reg + 3'd1;
                        end
                    end
                    S_PARITY: begin
                        tx_reg       <= 1'b1;
                        tx_state_reg <= S_STOP;
                    end
                    default: begin
                        tx_reg       <= 1'b1;
                        tx_state_reg <= S_IDLE;
                    end
                endcase
            end else begin
                tx_cnt_reg <= tx_cnt_reg + 16'd1;
            end
        end
    end

    assign o_Tx          = tx_reg;
    assign fifo_push[1]  = bus.we && (reg_sel == REG_DATA);
    assign fifo_wdata[1] = bus.w_data[DATA_BITS-1:0];
    assign fifo_pop[1]   = tx_pop;

    // ---------------- registers, flags, interrupt ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_reg        <= '0;
            div_reg         <= 16'(CLKS_PER_BIT);
            frame_err_reg   <= 1'b0;
            overrun_err_reg <= 1'b0;
            irq_reg         <= 1'b0;
        end else begin
            if (bus.we && reg_sel == REG_CTRL)
                ctrl_reg <= bus.w_data[2:0];
            if (bus.we && reg_sel == REG_DIV)
                div_reg <= (bus.w_data[15:0] < 16'd8) ? 16'd8 : bus.w_data[15:0];
            // A new error in the same cycle as its clear keeps the flag set.
            if (frame_set_reg)
                frame_err_reg <= 1'b1;
            else if (status_wr && bus.w_data[5])
                frame_err_reg <= 1'b0;
            if (rx_push_reg && !fifo_accept[0])
                overrun_err_reg <= 1'b1;
            else if (status_wr && bus.w_data[6])
                overrun_err_reg <= 1'b0;
            irq_reg <= (ctrl_reg[0] && !fifo_empty[0]) || (ctrl_reg[1] && fifo_empty[1]) ||
                       (ctrl_reg[2] && (frame_err_reg || overrun_err_reg || parity_err));
        end
    end

`ifdef UART_PARITY_EN
    logic parity_err_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_err_reg <= 1'b0;
        else if (parity_set_reg)
            parity_err_reg <= 1'b1;
        else if (status_wr && bus.w_data[7])
            parity_err_reg <= 1'b0;
    end
    assign parity_err = parity_err_reg;
`else
    logic unused_parity_set;
    assign unused_parity_set = parity_set_reg;
    assign parity_err        = 1'b0;
`endif

    assign bus.irq = irq_reg;

    always_comb begin
        bus.r_data = '0;
        case (reg_sel)
            REG_DATA:   bus.r_data[DATA_BITS-1:0] = fifo_head[0];
            REG_STATUS: bus.r_data[23:0] = {fifo_count8[1], fifo_count8[0], parity_err,
                                            overrun_err_reg, frame_err_reg, tx_busy, fifo_full[1],
                                            fifo_empty[1], fifo_full[0], fifo_empty[0]};
            REG_CTRL:   bus.r_data[2:0]  = ctrl_reg;
            default:    bus.r_data[15:0] = div_reg;
        endcase
    end
endmodule
